// File: rtl/pkt_ff_rd_ctrl.sv
// Read-domain control for the async packet FIFO.
// Ports:
//   clk, rst        - read clock, async active-high reset
//   wptr_gry_async  - gray write pointer, unsynchronised
//   rptr_gry        - gray read pointer (advances after rd_en)
//   rd_req, clr_err - consumer request, underflow clear
//   rd_en           - read pointer increment / RAM read
//   rd_valid        - RAM read data valid
//   empty, almost_empty, occupancy - registered status
//   underflow_err   - sticky: request seen while empty
module pkt_ff_rd_ctrl #(
    parameter int PTR_W     = 8,
    parameter int AE_THRESH = 2,
    parameter int RD_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PTR_W-1:0] wptr_gry_async,
    input  logic [PTR_W-1:0] rptr_gry,
    input  logic             rd_req,
    input  logic             clr_err,
    output logic             rd_en,
    output logic             rd_valid,
    output logic             empty,
    output logic             almost_empty,
    output logic [PTR_W-1:0] occupancy,
    output logic             underflow_err
);

    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0]  wsync1;
    logic [PTR_W-1:0]  wsync2;
    logic [PTR_W-1:0]  wbin;
    logic [PTR_W-1:0]  rbin;
    logic [PTR_W-1:0]  occ_nxt;
    logic [RD_LAT-1:0] pipe;

    function automatic logic [PTR_W-1:0] g2b(
        input logic [PTR_W-1:0] g
    );
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Plain two-flop synchroniser, nothing between stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wsync1 <= '0;
            wsync2 <= '0;
        end else begin
            wsync1 <= wptr_gry_async;
            wsync2 <= wsync1;
        end
    end

    assign wbin = g2b(wsync2);
    assign rbin = g2b(rptr_gry);

    assign rd_en = rd_req & ~empty;

    // rd_en is subtracted because rptr_gry only reflects
    // this read on the next cycle. Modulo wrap is intended.
    always_comb begin
        occ_nxt = wbin - rbin - PTR_W'(rd_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            occupancy    <= occ_nxt;
            empty        <= (occ_nxt == '0);
            almost_empty <= (occ_nxt <= AE_LVL);
        end
    end

    // RAM latency tracker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe[i] <= pipe[i-1];
            end
            pipe[0] <= rd_en;
        end
    end

    assign rd_valid = pipe[RD_LAT-1];

    // Set has priority over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_err <= 1'b0;
        end else if (rd_req && empty) begin
            underflow_err <= 1'b1;
        end else if (clr_err) begin
            underflow_err <= 1'b0;
        end
    end

endmodule
